reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file with rename tags, downstream of the reorder buffer.
//  Consumes the buffer's commit stream (reg_write/reg_rd/reg_val/commit_rob_pos) and records, at issue,
//  which buffer entry will produce each register.
//  Serves decoder operand lookups: value if clean, producer entry position if busy.
//  Rollback drops all rename tags; committed values are kept.
// PARAMETERS
//  ROB_POS_W  4   width of a reorder-buffer entry index (16 entries)
//  REG_NUM    32  number of architectural registers; index width 5
// PORTS
//  clk             in   1    clock, all state updates on rising edge
//  rst             in   1    asynchronous, active-high reset
//  rdy             in   1    global enable; low = hold all state
//  rollback        in   1    mispredict flush from reorder buffer
//  issue           in   1    decoder issues an instruction this cycle
//  issue_rd        in   5    destination register of issued instruction
//  issue_rob_pos   in   4    buffer entry allocated to issued instruction
//  reg_write       in   1    commit writes a register this cycle
//  reg_rd          in   5    committed destination register
//  reg_val         in   32   committed value
//  commit_rob_pos  in   4    buffer entry being committed
//  rs1 / rs2       in   5    decoder source register indices
//  rs1_val/rs2_val out  32   operand value (valid when busy=0)
//  rs1_busy/rs2_busy out 1   operand still pending in reorder buffer
//  rs1_rob_pos/rs2_rob_pos out 4  producing entry when busy=1
// BEHAVIOUR
//  - State: val[32] x32b, busy[32], tag[32] x ROB_POS_W.
//  - Reset (async, rst=1): all val=0, busy=0, tag=0.
//    Outputs follow combinationally: val=0, busy=0, rob_pos=0.
//  - rdy=0: no state change. Read outputs stay live.
//  - Commit, when reg_write && reg_rd!=0:
//    - val[reg_rd]<=reg_val.
//    - Clear busy[reg_rd] only if tag[reg_rd]==commit_rob_pos and no same-cycle issue to reg_rd;
//      otherwise the younger tag stays.
//  - Issue, when issue && issue_rd!=0: busy[issue_rd]<=1, tag<=issue_rob_pos.
//    Issue has priority over the commit clear on the same register.
//  - Rollback=1: all busy<=0 in that cycle; the tag array is left stale.
//    - A concurrent reg_write still writes val, since the commit that raised rollback may itself write rd.
//    - A concurrent issue is ignored.
//  - x0: never written, never busy; reads return val=0, busy=0.
//  - Reads are combinational, with commit forwarding:
//    - If reg_write && reg_rd==rsN && rsN!=0 && busy[rsN] && tag[rsN]==commit_rob_pos:
//      busy_out=0, val_out=reg_val.
//    - Otherwise busy_out=busy[rsN], val_out=val[rsN], rob_pos_out=tag[rsN].
//  - Same-cycle issue does not affect reads: an instruction naming its own rd as a source
//    sees the older producer.
//  - Read-to-output latency is 0 cycles. Write-to-state latency is 1 cycle.
//  - Tag-position wrap-around needs no handling: the buffer never holds two live entries with one index.
// TESTING
//  - Reset mid-run: write x5=7, assert rst asynchronously between edges
//    -> rs1=5 gives val=0, busy=0 immediately.
//  - Issue rd=3 pos=2, then commit rd=3 pos=2 val=0xAB
//    -> busy 1 after issue; in the commit cycle rs1=3 gives busy=0 val=0xAB; next cycle val[3]=0xAB.
//  - Issue rd=4 pos=1, issue rd=4 pos=5, commit pos=1 val=9
//    -> val[4]=9 but busy stays 1, rob_pos=5.
//  - Same-cycle commit rd=6 pos=2 and issue rd=6 pos=7
//    -> next cycle busy=1, tag=7, val=committed value.
//  - Issue rd=8,9,10, then rollback with concurrent reg_write rd=1 val=0x44
//    -> all busy=0 next cycle, val[1]=0x44.
//  - Writes/issues to x0, and rdy=0 during a commit
//    -> x0 stays 0 and not busy; with rdy=0 no state changes.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with rename tags: holds committed values and, per register,
// the reorder-buffer entry that will produce its next value.
module reg_file #(
    parameter int unsigned ROB_POS_W = 4,
    parameter int unsigned REG_NUM   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 reg_write,
    input  logic [4:0]           reg_rd,
    input  logic [31:0]          reg_val,
    input  logic [ROB_POS_W-1:0] commit_rob_pos,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_POS_W-1:0] rs1_rob_pos,
    output logic [ROB_POS_W-1:0] rs2_rob_pos
);

    logic [31:0]          val_q  [REG_NUM];
    logic [ROB_POS_W-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;

    logic commit_en;
    logic issue_en;
    logic fwd1;
    logic fwd2;

    assign commit_en = reg_write && (reg_rd != 5'd0);
    assign issue_en  = issue && (issue_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            if (commit_en) begin
                val_q[reg_rd] <= reg_val;
                // Only the producer we are waiting on may release the register.
                if (tag_q[reg_rd] == commit_rob_pos && !(issue_en && issue_rd == reg_rd)) begin
                    busy_q[reg_rd] <= 1'b0;
                end
            end
            if (rollback) begin
                busy_q <= '0;
            end else if (issue_en) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_pos;
            end
        end
    end

    // Commit forwarding: a value retiring this cycle is visible to readers immediately.
    assign fwd1 = reg_write && (reg_rd == rs1) && (rs1 != 5'd0) && busy_q[rs1]
                  && (tag_q[rs1] == commit_rob_pos);
    assign fwd2 = reg_write && (reg_rd == rs2) && (rs2 != 5'd0) && busy_q[rs2]
                  && (tag_q[rs2] == commit_rob_pos);

    always_comb begin
        rs1_val     = fwd1 ? reg_val : val_q[rs1];
        rs1_busy    = fwd1 ? 1'b0 : busy_q[rs1];
        rs1_rob_pos = tag_q[rs1];
        rs2_val     = fwd2 ? reg_val : val_q[rs2];
        rs2_busy    = fwd2 ? 1'b0 : busy_q[rs2];
        rs2_rob_pos = tag_q[rs2];
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected read results are queued as stimulus is driven
// and popped/compared once the combinational outputs have settled.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_pos;
    logic        reg_write;
    logic [4:0]  reg_rd;
    logic [31:0] reg_val;
    logic [3:0]  commit_rob_pos;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_rob_pos;
    logic [3:0]  rs2_rob_pos;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  pos;
    } exp_t;

    exp_t exp_q[$];

    reg_file #(
        .ROB_POS_W(4),
        .REG_NUM  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rollback      (rollback),
        .issue         (issue),
        .issue_rd      (issue_rd),
        .issue_rob_pos (issue_rob_pos),
        .reg_write     (reg_write),
        .reg_rd        (reg_rd),
        .reg_val       (reg_val),
        .commit_rob_pos(commit_rob_pos),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_rob_pos   (rs1_rob_pos),
        .rs2_rob_pos   (rs2_rob_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_rd(input string name, input bit port, input logic [31:0] val,
                             input logic busy, input logic [3:0] pos);
        exp_t e;
        e.name = name;
        e.port = port;
        e.val  = val;
        e.busy = busy;
        e.pos  = pos;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.port == 1'b0) begin
                check({e.name, ".val"}, rs1_val, e.val);
                check({e.name, ".busy"}, {31'd0, rs1_busy}, {31'd0, e.busy});
                if (e.busy) check({e.name, ".pos"}, {28'd0, rs1_rob_pos}, {28'd0, e.pos});
            end else begin
                check({e.name, ".val"}, rs2_val, e.val);
                check({e.name, ".busy"}, {31'd0, rs2_busy}, {31'd0, e.busy});
                if (e.busy) check({e.name, ".pos"}, {28'd0, rs2_rob_pos}, {28'd0, e.pos});
            end
        end
    endtask

    task automatic idle();
        rdy            = 1'b1;
        rollback       = 1'b0;
        issue          = 1'b0;
        issue_rd       = 5'd0;
        issue_rob_pos  = 4'd0;
        reg_write      = 1'b0;
        reg_rd         = 5'd0;
        reg_val        = 32'd0;
        commit_rob_pos = 4'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        issue         = 1'b1;
        issue_rd      = rd;
        issue_rob_pos = pos;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
        reg_write      = 1'b1;
        reg_rd         = rd;
        commit_rob_pos = pos;
        reg_val        = v;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        idle();
        rs1 = 5'd0;
        rs2 = 5'd31;

        // Reset state
        @(negedge clk);
        expect_rd("reset_x0", 1'b0, 32'd0, 1'b0, 4'd0);
        expect_rd("reset_x31", 1'b1, 32'd0, 1'b0, 4'd0);
        drain();
        rst = 1'b0;
        step();

        // Asynchronous reset mid-run
        do_commit(5'd5, 4'd0, 32'd7);
        step();
        idle();
        rs1 = 5'd5;
        expect_rd("x5_written", 1'b0, 32'd7, 1'b0, 4'd0);
        drain();
        rst = 1'b1;
        expect_rd("x5_async_rst", 1'b0, 32'd0, 1'b0, 4'd0);
        drain();
        step();
        rst = 1'b0;

        // Issue then matching commit, with forwarding
        do_issue(5'd3, 4'd2);
        step();
        idle();
        rs1 = 5'd3;
        expect_rd("x3_issued", 1'b0, 32'd0, 1'b1, 4'd2);
        drain();
        do_commit(5'd3, 4'd2, 32'hAB);
        expect_rd("x3_fwd", 1'b0, 32'hAB, 1'b0, 4'd0);
        drain();
        step();
        idle();
        expect_rd("x3_committed", 1'b0, 32'hAB, 1'b0, 4'd0);
        drain();

        // Younger producer keeps the register busy
        do_issue(5'd4, 4'd1);
        step();
        do_issue(5'd4, 4'd5);
        step();
        idle();
        do_commit(5'd4, 4'd1, 32'd9);
        rs1 = 5'd4;
        expect_rd("x4_no_fwd", 1'b0, 32'd0, 1'b1, 4'd5);
        drain();
        step();
        idle();
        rs2 = 5'd4;
        expect_rd("x4_val", 1'b0, 32'd9, 1'b1, 4'd5);
        expect_rd("x4_val_rs2", 1'b1, 32'd9, 1'b1, 4'd5);
        drain();

        // Same-cycle commit and issue to one register
        do_issue(5'd6, 4'd2);
        step();
        idle();
        do_commit(5'd6, 4'd2, 32'h66);
        do_issue(5'd6, 4'd7);
        rs1 = 5'd6;
        expect_rd("x6_fwd_old_producer", 1'b0, 32'h66, 1'b0, 4'd0);
        drain();
        step();
        idle();
        expect_rd("x6_reissued", 1'b0, 32'h66, 1'b1, 4'd7);
        drain();

        // Rollback with concurrent commit write and ignored issue
        do_issue(5'd8, 4'd3);
        step();
        do_issue(5'd9, 4'd4);
        step();
        do_issue(5'd10, 4'd5);
        step();
        idle();
        rs1 = 5'd9;
        expect_rd("x9_busy", 1'b0, 32'd0, 1'b1, 4'd4);
        drain();
        rollback = 1'b1;
        do_commit(5'd1, 4'd0, 32'h44);
        do_issue(5'd11, 4'd6);
        step();
        idle();
        rs1 = 5'd8;
        rs2 = 5'd10;
        expect_rd("x8_rolled_back", 1'b0, 32'd0, 1'b0, 4'd0);
        expect_rd("x10_rolled_back", 1'b1, 32'd0, 1'b0, 4'd0);
        drain();
        check("x8_stale_tag", {28'd0, rs1_rob_pos}, 32'd3);
        rs1 = 5'd1;
        rs2 = 5'd11;
        expect_rd("x1_commit_in_rollback", 1'b0, 32'h44, 1'b0, 4'd0);
        expect_rd("x11_issue_ignored", 1'b1, 32'd0, 1'b0, 4'd0);
        drain();

        // x0 is never written or busy
        do_issue(5'd0, 4'd9);
        do_commit(5'd0, 4'd9, 32'hFFFF_FFFF);
        rs1 = 5'd0;
        expect_rd("x0_no_fwd", 1'b0, 32'd0, 1'b0, 4'd0);
        drain();
        step();
        idle();
        expect_rd("x0_after", 1'b0, 32'd0, 1'b0, 4'd0);
        drain();
        check("x0_tag", {28'd0, rs1_rob_pos}, 32'd0);

        // rdy=0 holds all state
        do_issue(5'd12, 4'd3);
        step();
        idle();
        rdy = 1'b0;
        do_commit(5'd12, 4'd3, 32'h55);
        do_issue(5'd13, 4'd4);
        step();
        idle();
        rs1 = 5'd12;
        rs2 = 5'd13;
        expect_rd("x12_held", 1'b0, 32'd0, 1'b1, 4'd3);
        expect_rd("x13_held", 1'b1, 32'd0, 1'b0, 4'd0);
        drain();
        do_commit(5'd12, 4'd3, 32'h55);
        step();
        idle();
        expect_rd("x12_committed", 1'b0, 32'h55, 1'b0, 4'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
